// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the all-dark pattern and active-low glyphs (bit order g..a).
package seg_pkg;

    localparam int SEG_A      = 0;
    localparam int SEG_G      = 6;
    localparam int SEG_DP_BIT = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef logic [3:0] seg_code_t;
    typedef logic [6:0] seg_glyph_t;

    localparam seg_glyph_t GLYPH_0 = 7'h40;
    localparam seg_glyph_t GLYPH_1 = 7'h79;
    localparam seg_glyph_t GLYPH_2 = 7'h24;
    localparam seg_glyph_t GLYPH_3 = 7'h30;
    localparam seg_glyph_t GLYPH_4 = 7'h19;
    localparam seg_glyph_t GLYPH_5 = 7'h12;
    localparam seg_glyph_t GLYPH_6 = 7'h02;
    localparam seg_glyph_t GLYPH_7 = 7'h78;
    localparam seg_glyph_t GLYPH_8 = 7'h00;
    localparam seg_glyph_t GLYPH_9 = 7'h10;
    localparam seg_glyph_t GLYPH_A = 7'h08;
    localparam seg_glyph_t GLYPH_B = 7'h03;
    localparam seg_glyph_t GLYPH_C = 7'h46;
    localparam seg_glyph_t GLYPH_D = 7'h21;
    localparam seg_glyph_t GLYPH_E = 7'h06;
    localparam seg_glyph_t GLYPH_F = 7'h0E;

    // Shown for non-decimal codes when hex glyphs are not built in.
    localparam seg_glyph_t GLYPH_ERR = GLYPH_E;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational code-to-glyph map (active low, g..a).
// Define SEG_HEX_EN to show A b C d E F for codes 10..15; otherwise they show E.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_glyph
);

    always_comb begin
        o_glyph = GLYPH_ERR;
        case (i_code)
            4'd0: o_glyph = GLYPH_0;
            4'd1: o_glyph = GLYPH_1;
            4'd2: o_glyph = GLYPH_2;
            4'd3: o_glyph = GLYPH_3;
            4'd4: o_glyph = GLYPH_4;
            4'd5: o_glyph = GLYPH_5;
            4'd6: o_glyph = GLYPH_6;
            4'd7: o_glyph = GLYPH_7;
            4'd8: o_glyph = GLYPH_8;
            4'd9: o_glyph = GLYPH_9;
`ifdef SEG_HEX_EN
            4'd10: o_glyph = GLYPH_A;
            4'd11: o_glyph = GLYPH_B;
            4'd12: o_glyph = GLYPH_C;
            4'd13: o_glyph = GLYPH_D;
            4'd14: o_glyph = GLYPH_E;
            4'd15: o_glyph = GLYPH_F;
`else
            default: o_glyph = GLYPH_ERR;
`endif
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: prescaled 16-phase PWM per digit, frame latch,
// leading-zero blanking. Optional hex glyphs via SEG_HEX_EN (see seg_glyph_decode).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_input,
    input  logic [NUM_DIGITS-1:0]   dp_input,
    input  logic [3:0]              brightness,
    input  logic                    blank,
    input  logic                    lzb_en,
    output logic [7:0]              segment_outputs,
    output logic [NUM_DIGITS-1:0]   anode_select,
    output logic                    frame_start
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);

    logic [PW-1:0]           r_presc;
    logic [3:0]              r_phase;
    logic [DW-1:0]           r_digit;
    logic                    r_need_latch;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [3:0]              r_bright;
    logic                    r_lzb;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_frame_start;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_latch;
    logic [3:0]              w_code;
    logic [6:0]              w_glyph;
    logic [7:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_lzb_dark;
    logic                    w_zero_run;
    logic                    w_lit;

    assign w_tick  = (r_presc == LAST_PRESC);
    assign w_wrap  = w_tick && (r_phase == 4'hF) && (r_digit == LAST_DIGIT);
    assign w_latch = r_need_latch || w_wrap;

    // The first cycle after reset only latches the frame; scanning starts after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_phase      <= '0;
            r_digit      <= '0;
            r_need_latch <= 1'b1;
        end else if (r_need_latch) begin
            r_need_latch <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_phase <= r_phase + 1'b1;
                if (r_phase == 4'hF) begin
                    r_digit <= (r_digit == LAST_DIGIT) ? '0 : r_digit + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd         <= '0;
            r_dp          <= '0;
            r_bright      <= '0;
            r_lzb         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_latch;
            if (w_latch) begin
                r_bcd    <= bcd_input;
                r_dp     <= dp_input;
                r_bright <= brightness;
                r_lzb    <= lzb_en;
            end
        end
    end

    // A digit is dark under blanking when it and every higher digit hold code 0.
    always_comb begin
        w_zero_run = 1'b1;
        w_lzb_dark = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run    = w_zero_run && (r_bcd[4*k +: 4] == 4'h0);
            w_lzb_dark[k] = w_zero_run && (k != 0);
        end
    end

    assign w_code = r_bcd[{r_digit, 2'b00} +: 4];

    seg_glyph_decode u_decode (
        .i_code  (w_code),
        .o_glyph (w_glyph)
    );

    always_comb begin
        w_seg             = SEG_OFF;
        w_seg[SEG_G:SEG_A] = w_glyph;
        w_seg[SEG_DP_BIT] = ~r_dp[r_digit];
    end

    assign w_lit = !r_need_latch && !blank && (r_phase <= r_bright)
                   && !(r_lzb && w_lzb_dark[r_digit]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= SEG_OFF;
            r_anode <= '0;
        end else begin
            r_seg   <= w_lit ? w_seg : SEG_OFF;
            r_anode <= w_lit ? (NUM_DIGITS'(1) << r_digit) : '0;
        end
    end

    assign segment_outputs = r_seg;
    assign anode_select    = r_anode;
    assign frame_start     = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, 2 clocks per brightness phase),
// with a timeline-based reference model of the display.
module tb_seg_scan_driver;

    localparam int N         = 4;
    localparam int SD        = 2;
    localparam int DIGIT_CYC = 16 * SD;
    localparam int FRAME_CYC = N * DIGIT_CYC;
    localparam int W         = 1 + N + 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [4*N-1:0] bcd_input;
    logic [N-1:0]   dp_input;
    logic [3:0]     brightness;
    logic           blank;
    logic           lzb_en;
    logic [7:0]     segment_outputs;
    logic [N-1:0]   anode_select;
    logic           frame_start;

    seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk             (clk),
        .rst             (rst),
        .bcd_input       (bcd_input),
        .dp_input        (dp_input),
        .brightness      (brightness),
        .blank           (blank),
        .lzb_en          (lzb_en),
        .segment_outputs (segment_outputs),
        .anode_select    (anode_select),
        .frame_start     (frame_start)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    // Reference model state: edges since reset release and the frame on display.
    int             m_edge;
    logic [4*N-1:0] m_bcd;
    logic [N-1:0]   m_dp;
    logic [3:0]     m_bright;
    logic           m_lzb;

    function automatic logic [7:0] ref_glyph(input int code);
        case (code)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
`ifdef SEG_HEX_EN
            10: return 8'h88;
            11: return 8'h83;
            12: return 8'hC6;
            13: return 8'hA1;
            14: return 8'h86;
            15: return 8'h8E;
`endif
            default: return 8'h86;
        endcase
    endfunction

    task automatic model_reset();
        m_edge   = 0;
        m_bcd    = '0;
        m_dp     = '0;
        m_bright = '0;
        m_lzb    = 1'b0;
    endtask

    // Predict the outputs after the coming rising edge from the current inputs.
    task automatic model_step();
        int           pos, dig, ph;
        logic         fs, lit;
        logic [N-1:0] an;
        logic [7:0]   seg;
        m_edge++;
        fs  = (m_edge == 1) || ((m_edge - 1) % FRAME_CYC == 0);
        an  = '0;
        seg = 8'hFF;
        if (m_edge >= 2 && !blank) begin
            pos = (m_edge - 2) % FRAME_CYC;
            dig = pos / DIGIT_CYC;
            ph  = (pos % DIGIT_CYC) / SD;
            lit = (ph <= int'(m_bright));
            if (m_lzb && dig > 0 && (m_bcd >> (4 * dig)) == 0) lit = 1'b0;
            if (lit) begin
                an     = N'(1) << dig;
                seg    = ref_glyph(int'(m_bcd[4*dig +: 4]));
                seg[7] = ~m_dp[dig];
            end
        end
        exp_q.push_back({fs, an, seg});
        if (fs) begin
            m_bcd    = bcd_input;
            m_dp     = dp_input;
            m_bright = brightness;
            m_lzb    = lzb_en;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int d = 0; d < N; d++)
                    bcd_input[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                dp_input   = N'($urandom);
                brightness = 4'($urandom_range(0, 15));
                lzb_en     = 1'($urandom);
            end
            if ($urandom_range(0, 99) == 0) blank = ~blank;
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (segment_outputs === 8'hFF && anode_select === '0 && frame_start === 1'b0)
            passes++;
        else
            $display("FAIL %s: seg=%h anode=%b fs=%b, required seg=ff anode=0000 fs=0",
                     name, segment_outputs, anode_select, frame_start);
    endtask

    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({frame_start, anode_select, segment_outputs} === e)
                passes++;
            else
                $display("FAIL scan t=%0t: fs=%b anode=%b seg=%h, required fs=%b anode=%b seg=%h",
                         $time, frame_start, anode_select, segment_outputs,
                         e[W-1], e[W-2 -: N], e[7:0]);
        end
    end

    initial begin
        rst        = 1'b1;
        bcd_input  = 16'h1234;
        dp_input   = '0;
        brightness = 4'd15;
        blank      = 1'b0;
        lzb_en     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        // Full brightness digits 1234, then 1/4 duty.
        run_cycles(2 * FRAME_CYC);
        brightness = 4'd3;
        run_cycles(FRAME_CYC + 10);

        // Leading-zero blanking of 0050 with a decimal point on digit 1.
        bcd_input  = 16'h0050;
        dp_input   = 4'b0010;
        brightness = 4'd15;
        lzb_en     = 1'b1;
        run_cycles(2 * FRAME_CYC);

        // Inputs changed mid-frame take effect only at the next frame.
        lzb_en    = 1'b0;
        dp_input  = '0;
        bcd_input = 16'h1234;
        run_cycles(FRAME_CYC / 2 + 3 * DIGIT_CYC / 2);
        bcd_input = 16'h5678;
        run_cycles(2 * FRAME_CYC);

        // Non-decimal code with its decimal point lit.
        bcd_input = 16'h000A;
        dp_input  = 4'b0001;
        run_cycles(FRAME_CYC + 5);

        // Asynchronous reset in the middle of a lit digit.
        bcd_input = 16'h9876;
        run_cycles(FRAME_CYC + 40);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_midscan");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_cycles(FRAME_CYC + 20);

        run_random(20 * FRAME_CYC);
        blank = 1'b0;
        run_cycles(FRAME_CYC);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
